// File: rtl/hamming_pkg.sv
// Shared definitions for the (16,11) SECDED serial link.
// Imported by the transmitter, its codeword generator and the decoder.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CW_W   = 16;
  localparam int PAR_W  = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CW_W-1:0]   cw_t;
  typedef logic [PAR_W-1:0]  pos_t;

  // Codeword position of data bit i, ascending, skipping powers of two.
  localparam pos_t DPOS [DATA_W] = '{
    4'd3,  4'd5,  4'd6,  4'd7,
    4'd9,  4'd10, 4'd11, 4'd12,
    4'd13, 4'd14, 4'd15
  };

  // Codeword position of check bit k.
  localparam pos_t CPOS [PAR_W] = '{
    4'd1, 4'd2, 4'd4, 4'd8
  };

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/hamming_cw_gen.sv
// Combinational (16,11) extended Hamming encoder.
// Position 0 carries overall parity of positions 1..15.
module hamming_cw_gen
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   cw
);

  logic [PAR_W-1:0] chk;
  logic [CW_W-1:0]  word;
  pos_t             p;

  // Scatter data, fold check bits, then close overall parity.
  always_comb begin
    chk  = '0;
    word = '0;
    p    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      p = DPOS[i];
      word[p] = data[i];
      for (int k = 0; k < PAR_W; k++) begin
        chk[k] = chk[k] ^ (data[i] & p[k]);
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      word[CPOS[k]] = chk[k];
    end
    word[0] = ^word[CW_W-1:1];
    cw = word;
  end

endmodule

// File: rtl/hamming_tx.sv
// Serial SECDED transmitter: accept 11-bit word, shift 16-bit codeword.
// Position 0 first; back-to-back reload at pos 15 keeps frames gapless.
module hamming_tx
  import hamming_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              tx_en,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              busy
);

  localparam pos_t LAST = pos_t'(CW_W - 1);

  state_t          state;
  pos_t            pos;
  logic [CW_W-1:0] shreg;
  logic [CW_W-1:0] cw;
  logic            last;
  logic            take;

  hamming_cw_gen u_cw_gen (
    .data (in_data),
    .cw   (cw)
  );

  assign last = (state == SEND) && (pos == LAST) && tx_en;
  assign take = in_valid && in_ready;

  // Ready when idle or on the final enabled bit of a frame.
  always_comb begin
    in_ready = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready = 1'b1;
      last:            in_ready = 1'b1;
      default:         in_ready = 1'b0;
    endcase
  end

  // Frame FSM with registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pos      <= '0;
      shreg    <= '0;
      tx_bit   <= IDLE_LEVEL;
      tx_valid <= 1'b0;
      tx_sof   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            state    <= SEND;
            pos      <= '0;
            shreg    <= cw;
            tx_bit   <= cw[0];
            tx_valid <= 1'b1;
            tx_sof   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SEND: begin
          if (tx_en) begin
            if (pos == LAST) begin
              if (take) begin
                pos      <= '0;
                shreg    <= cw;
                tx_bit   <= cw[0];
                tx_sof   <= 1'b1;
              end else begin
                state    <= IDLE;
                shreg    <= '0;
                tx_bit   <= IDLE_LEVEL;
                tx_valid <= 1'b0;
                tx_sof   <= 1'b0;
                busy     <= 1'b0;
              end
            end else begin
              pos    <= pos + 4'd1;
              shreg  <= shreg >> 1;
              tx_bit <= shreg[1];
              tx_sof <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_tx.sv
// Scoreboard bench for hamming_tx with a serial decoder model.
// Driver pushes expected frames; negedge monitor pops and checks.
module tb_hamming_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        tx_en = 1'b1;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_sof;
  logic        busy;

  hamming_tx #(.IDLE_LEVEL(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_en    (tx_en),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .tx_sof   (tx_sof),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] d;
    logic [15:0] cw;
    bit          has_cw;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_frames = 0;
  int   cycle = 0;
  int   acc_cyc = 0;
  bit   rnd_en = 1'b0;

  int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Random tx_en stalls during the sweep.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) tx_en = ($urandom_range(3) != 0);
    end
  end

  // Present a word and wait for it to be taken.
  task automatic send(logic [10:0] w, logic [15:0] cw, bit has_cw);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.d = w;
        e.cw = cw;
        e.has_cw = has_cw;
        q.push_back(e);
        acc_cyc = cycle;
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx_valid && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: rebuild frames, decode, and compare with scoreboard.
  logic [4:0]  cnt = '0;
  logic [15:0] frame = '0;
  logic [3:0]  syn = '0;
  logic        par = 1'b0;
  logic        was_stall = 1'b0;
  logic        last_bit = 1'b0;

  initial begin
    exp_t        e;
    logic [10:0] dx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = '0;
        syn = '0;
        par = 1'b0;
        was_stall = 1'b0;
        q.delete();
      end else if (tx_valid) begin
        chk("busy_eq_valid", {31'd0, busy}, 32'd1);
        chk("sof", {31'd0, tx_sof}, {31'd0, cnt == 5'd0});
        if (was_stall) chk("stall_hold", {31'd0, tx_bit}, {31'd0, last_bit});
        if (in_ready)
          chk("ready_at_15", {31'd0, cnt == 5'd15 && tx_en}, 32'd1);
        if (tx_en) begin
          frame[cnt[3:0]] = tx_bit;
          if (tx_bit) syn = syn ^ cnt[3:0];
          par = par ^ tx_bit;
          cnt = cnt + 5'd1;
          if (cnt == 5'd16) begin
            n_frames++;
            chk("syndrome", {28'd0, syn}, 32'd0);
            chk("parity", {31'd0, par}, 32'd0);
            if (q.size() == 0) begin
              chk("unexpected_frame", {16'd0, frame}, 32'hFFFF_FFFF);
            end else begin
              e = q.pop_front();
              dx = '0;
              for (int i = 0; i < 11; i++) dx[i] = frame[dpos[i]];
              chk("data_bits", {21'd0, dx}, {21'd0, e.d});
              if (e.has_cw) chk("codeword", {16'd0, frame}, {16'd0, e.cw});
            end
            cnt = '0;
            syn = '0;
            par = 1'b0;
          end
        end
        was_stall = !tx_en;
        last_bit = tx_bit;
      end else begin
        chk("idle_bit", {31'd0, tx_bit}, 32'd0);
        chk("idle_sof", {31'd0, tx_sof}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        chk("no_partial", {27'd0, cnt}, 32'd0);
        was_stall = 1'b0;
      end
    end
  end

  int a1;
  int a2;

  initial begin
    #12;
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_bit", {31'd0, tx_bit}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);

    send(11'h000, 16'h0000, 1'b1);
    drain();
    send(11'h001, 16'h000F, 1'b1);
    drain();
    send(11'h7FF, 16'hFFFF, 1'b1);
    drain();

    send(11'h002, 16'h0033, 1'b1);
    a1 = acc_cyc;
    send(11'h400, 16'h8117, 1'b1);
    a2 = acc_cyc;
    chk("b2b_gap1", a2 - a1, 32'd16);
    send(11'h003, 16'h003C, 1'b1);
    chk("b2b_gap2", acc_cyc - a2, 32'd16);
    drain();

    send(11'h400, 16'h8117, 1'b1);
    in_valid = 1'b0;
    tx_en = 1'b0;
    step(3);
    tx_en = 1'b1;
    step(9);
    tx_en = 1'b0;
    step(3);
    tx_en = 1'b1;
    step(6);
    tx_en = 1'b0;
    in_valid = 1'b1;
    in_data = 11'h003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_accept_stalled", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    tx_en = 1'b1;
    a1 = cycle;
    send(11'h003, 16'h003C, 1'b1);
    chk("accept_after_stall", acc_cyc - a1, 32'd0);
    drain();

    send(11'h7FF, 16'hFFFF, 1'b1);
    in_valid = 1'b0;
    step(7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, tx_valid}, 32'd0);
    chk("arst_sof", {31'd0, tx_sof}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_bit", {31'd0, tx_bit}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
    send(11'h002, 16'h0033, 1'b1);
    drain();

    a1 = n_frames;
    rnd_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      send(11'($urandom_range(2047)), 16'h0, 1'b0);
    end
    rnd_en = 1'b0;
    tx_en = 1'b1;
    drain();
    chk("sweep_frames", n_frames - a1, 32'd500);
    chk("queue_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
